// File: rtl/slc3_mem_pkg.sv
// Shared types and default timing for the SLC-3 SRAM arbiter.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } mem_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } req_id_t;

  localparam int unsigned SLC3_RD_WAIT = 2;
  localparam int unsigned SLC3_WR_WAIT = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and SRAM-side signal bundle for mem_arbiter.
// slave: the arbiter; master: requesters plus the SRAM pad model.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    input  sram_dq_in,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    output sram_dq_in,
    input  busy
  );

endinterface

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last.
module mem_rr_pick
  import slc3_mem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  // Decode the request pair into a winner.
  always_comb begin
    grant_valid = |req;
    grant_id    = CPU;
    unique case (req)
      2'b01:   grant_id = CPU;
      2'b10:   grant_id = DBG;
      2'b11:   grant_id = (last_grant == CPU) ? DBG : CPU;
      default: grant_id = CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// SLC-3 SRAM sequencer: arbitrates CPU and debug-loader requests onto one
// asynchronous SRAM port and generates registered active-low strobes.
module mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned RD_WAIT = SLC3_RD_WAIT,
  parameter int unsigned WR_WAIT = SLC3_WR_WAIT,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  mem_arbiter_if.slave  bus
);

  // Counter only needs to hold (wait - 1) for the longer access.
  localparam int unsigned MaxWait = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CW      = (MaxWait > 1) ? $clog2(MaxWait) : 1;

  mem_state_t    state_q;
  req_id_t       cur_id_q;
  logic          cur_we_q;
  req_id_t       last_grant_q;
  logic [CW-1:0] cnt_q;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] dq_out_q;
  logic          dq_oe_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;
  logic          cpu_ack_q;
  logic          dbg_ack_q;
  logic          busy_q;

  logic          grant_valid;
  req_id_t       grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  mem_rr_pick u_pick (
    .req         ({bus.dbg_req, bus.cpu_req}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Route the winning requester's fields to the latch point.
  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (grant_id == DBG) begin
      sel_we    = bus.dbg_we;
      sel_addr  = bus.dbg_addr;
      sel_wdata = bus.dbg_wdata;
    end
  end

  // Access sequencer: every output is a register updated alongside the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cur_id_q     <= CPU;
      cur_we_q     <= 1'b0;
      last_grant_q <= DBG;
      cnt_q        <= '0;
      addr_q       <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            cur_id_q     <= grant_id;
            cur_we_q     <= sel_we;
            last_grant_q <= grant_id;
            addr_q       <= sel_addr;
            ce_n_q       <= 1'b0;
            busy_q       <= 1'b1;
            if (sel_we) begin
              dq_out_q <= sel_wdata;
              dq_oe_q  <= 1'b1;
            end
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cur_we_q) begin
            cnt_q  <= CW'(WR_WAIT - 1);
            we_n_q <= 1'b0;
          end else begin
            cnt_q  <= CW'(RD_WAIT - 1);
            oe_n_q <= 1'b0;
          end
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            if (!cur_we_q) begin
              if (cur_id_q == DBG) dbg_rdata_q <= bus.sram_dq_in;
              else                 cpu_rdata_q <= bus.sram_dq_in;
            end
            if (cur_id_q == DBG) dbg_ack_q <= 1'b1;
            else                 cpu_ack_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          // Address and write data stayed put through this cycle for hold time.
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_ce_n   = ce_n_q;
  assign bus.sram_oe_n   = oe_n_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.dbg_ack     = dbg_ack_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: default-timing instance with an SRAM array model and
// an ack scoreboard, plus a RD_WAIT=4 / WR_WAIT=1 instance for latency.
module tb_mem_arbiter;
  import slc3_mem_pkg::*;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();
  mem_arbiter_if #(.AW(16), .DW(16)) bus2 ();

  mem_arbiter #(.RD_WAIT(2), .WR_WAIT(2), .AW(16), .DW(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  mem_arbiter #(.RD_WAIT(4), .WR_WAIT(1), .AW(16), .DW(16)) dut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus2)
  );

  // SRAM models
  logic [15:0] mem [0:1023];
  assign bus.sram_dq_in  = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr[9:0]] : 16'h0000;
  assign bus2.sram_dq_in = bus2.sram_addr ^ 16'h5A5A;

  always @(posedge Clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
      mem[bus.sram_addr[9:0]] <= bus.sram_dq_out;
  end

  // Protocol monitor and scoreboard
  logic prev_cpu_ack = 1'b0, prev_dbg_ack = 1'b0, prev2_cpu_ack = 1'b0;
  exp_t mon_e;
  logic [15:0] mon_rd;

  always @(negedge Clk) begin
    checks++;
    if ((!bus.sram_oe_n && !bus.sram_we_n) || (!bus2.sram_oe_n && !bus2.sram_we_n)) begin
      errors++;
      $display("FAIL protocol_oe_we: oe_n/we_n both low (bus %b%b, bus2 %b%b), required never",
               bus.sram_oe_n, bus.sram_we_n, bus2.sram_oe_n, bus2.sram_we_n);
    end
    checks++;
    if ((bus.sram_ce_n && (!bus.sram_oe_n || !bus.sram_we_n)) ||
        (bus.sram_dq_oe && !bus.sram_oe_n) || (bus2.sram_dq_oe && !bus2.sram_oe_n)) begin
      errors++;
      $display("FAIL protocol_strobe: ce_n=%b oe_n=%b we_n=%b dq_oe=%b, required legal strobes",
               bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe);
    end
    checks++;
    if ((bus.cpu_ack && prev_cpu_ack) || (bus.dbg_ack && prev_dbg_ack) ||
        (bus2.cpu_ack && prev2_cpu_ack)) begin
      errors++;
      $display("FAIL ack_width: ack high two cycles in a row, required 1-cycle pulse");
    end
    prev_cpu_ack  <= bus.cpu_ack;
    prev_dbg_ack  <= bus.dbg_ack;
    prev2_cpu_ack <= bus2.cpu_ack;

    if (bus.cpu_ack || bus.dbg_ack) begin
      checks++;
      if (bus.cpu_ack && bus.dbg_ack) begin
        errors++;
        $display("FAIL sb_dual_ack: both acks high, required one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: ack cpu=%b dbg=%b with no transaction outstanding",
                 bus.cpu_ack, bus.dbg_ack);
      end else begin
        mon_e  = sb.pop_front();
        mon_rd = bus.dbg_ack ? bus.dbg_rdata : bus.cpu_rdata;
        if (bus.dbg_ack !== mon_e.id) begin
          errors++;
          $display("FAIL sb_order: granted id %0d, required %0d", bus.dbg_ack, mon_e.id);
        end else if (!mon_e.we && mon_rd !== mon_e.data) begin
          errors++;
          $display("FAIL sb_rdata: got %h, required %h", mon_rd, mon_e.data);
        end else if (mon_e.we && mem[mon_e.addr[9:0]] !== mon_e.data) begin
          errors++;
          $display("FAIL sb_wdata: mem[%h]=%h, required %h", mon_e.addr,
                   mem[mon_e.addr[9:0]], mon_e.data);
        end
      end
    end
  end

  // Drive one transaction on bus and count strobe activity until its ack.
  task automatic run_txn(input logic id, input logic we, input logic [15:0] addr,
                         input logic [15:0] data, output int lat, output int oe_lo,
                         output int we_lo, output int dq_hi, output int other_ack,
                         output bit timeout);
    bit found = 1'b0;
    lat = 0; oe_lo = 0; we_lo = 0; dq_hi = 0; other_ack = 0;
    sb.push_back('{id: id, we: we, addr: addr, data: data});
    if (id) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = data;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = data;
    end
    for (int c = 1; c <= 40 && !found; c++) begin
      @(posedge Clk);
      #1;
      if (!bus.sram_oe_n) oe_lo++;
      if (!bus.sram_we_n) we_lo++;
      if (bus.sram_dq_oe) dq_hi++;
      if (id ? bus.cpu_ack : bus.dbg_ack) other_ack++;
      if (id ? bus.dbg_ack : bus.cpu_ack) begin
        found = 1'b1;
        lat   = c + 1;
      end
    end
    timeout = !found;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n} !== 3'b111) begin
      errors++;
      $display("FAIL reset_strobes: %b, required 111",
               {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n});
    end
    checks++;
    if (bus.sram_dq_oe !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe_busy: dq_oe=%b busy=%b, required 0 0", bus.sram_dq_oe, bus.busy);
    end
    checks++;
    if (bus.sram_addr !== 16'h0 || bus.sram_dq_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr_data: addr=%h dq_out=%h, required 0 0",
               bus.sram_addr, bus.sram_dq_out);
    end
    checks++;
    if (bus.cpu_rdata !== 16'h0 || bus.dbg_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: cpu=%h dbg=%h, required 0 0", bus.cpu_rdata, bus.dbg_rdata);
    end
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: cpu=%b dbg=%b, required 0 0", bus.cpu_ack, bus.dbg_ack);
    end
  endtask

  task automatic test_read();
    int lat, oe_lo, we_lo, dq_hi, oth;
    bit to;
    run_txn(1'b0, 1'b0, 16'h0040, 16'h1234, lat, oe_lo, we_lo, dq_hi, oth, to);
    checks++;
    if (to || lat != 5) begin
      errors++;
      $display("FAIL read_latency: timeout=%0d cycle=%0d, required cycle 5", to, lat);
    end
    checks++;
    if (oe_lo != 2 || we_lo != 0 || dq_hi != 0) begin
      errors++;
      $display("FAIL read_strobes: oe_lo=%0d we_lo=%0d dq_oe=%0d, required 2 0 0",
               oe_lo, we_lo, dq_hi);
    end
    checks++;
    if (bus.cpu_rdata !== 16'h1234 || oth != 0 || bus.dbg_rdata !== 16'h0) begin
      errors++;
      $display("FAIL read_data: cpu_rdata=%h dbg_ack=%0d dbg_rdata=%h, required 1234 0 0000",
               bus.cpu_rdata, oth, bus.dbg_rdata);
    end
  endtask

  task automatic test_write();
    int lat, oe_lo, we_lo, dq_hi, oth;
    bit to;
    run_txn(1'b1, 1'b1, 16'h00FF, 16'hBEEF, lat, oe_lo, we_lo, dq_hi, oth, to);
    checks++;
    if (to || lat != 5) begin
      errors++;
      $display("FAIL write_latency: timeout=%0d cycle=%0d, required cycle 5", to, lat);
    end
    checks++;
    if (we_lo != 2 || oe_lo != 0 || dq_hi != 4) begin
      errors++;
      $display("FAIL write_strobes: we_lo=%0d oe_lo=%0d dq_oe=%0d, required 2 0 4",
               we_lo, oe_lo, dq_hi);
    end
    checks++;
    if (mem[10'h0FF] !== 16'hBEEF || oth != 0 || bus.cpu_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL write_data: mem=%h cpu_ack=%0d cpu_rdata=%h, required beef 0 1234",
               mem[10'h0FF], oth, bus.cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic order [4];
    logic exp_order [4];
    int n = 0;
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{id: 1'b0, we: 1'b0, addr: 16'h0010, data: 16'h0030});
      sb.push_back('{id: 1'b1, we: 1'b1, addr: 16'h0020, data: 16'hCAFE});
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0020; bus.dbg_wdata = 16'hCAFE;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(posedge Clk);
      #1;
      if (bus.cpu_ack || bus.dbg_ack) begin
        order[n] = bus.dbg_ack;
        n++;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d acks, required 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: id %0d, required %0d", i, order[i], exp_order[i]);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_mid_reset();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0030; bus.dbg_wdata = 16'h1111;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (bus.sram_we_n !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: we_n=%b busy=%b, required 0 1", bus.sram_we_n, bus.busy);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe} !== 4'b1110 ||
        bus.dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: ce/oe/we/dq_oe=%b ack=%b, required 1110 0",
               {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}, bus.dbg_ack);
    end
    bus.dbg_req = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b state=%0d, required 0 IDLE", bus.busy, dut.state_q);
    end
  endtask

  task automatic test_params();
    int lat;
    for (int t = 0; t < 2; t++) begin
      lat = 0;
      bus2.cpu_req   = 1'b1;
      bus2.cpu_we    = (t == 1);
      bus2.cpu_addr  = 16'h0123;
      bus2.cpu_wdata = 16'h7777;
      for (int c = 1; c <= 30 && lat == 0; c++) begin
        @(posedge Clk);
        #1;
        if (bus2.cpu_ack) lat = c + 1;
      end
      bus2.cpu_req = 1'b0;
      checks++;
      if (lat != ((t == 1) ? 4 : 7)) begin
        errors++;
        $display("FAIL param_latency[%s]: cycle %0d, required %0d",
                 (t == 1) ? "wr" : "rd", lat, (t == 1) ? 4 : 7);
      end
      if (t == 0) begin
        checks++;
        if (bus2.cpu_rdata !== (16'h0123 ^ 16'h5A5A)) begin
          errors++;
          $display("FAIL param_rdata: %h, required %h", bus2.cpu_rdata, 16'h0123 ^ 16'h5A5A);
        end
      end
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 16'(i * 3);
    mem[64] <= 16'h1234;
  end

  initial begin
    Reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    bus2.dbg_req = 1'b0; bus2.dbg_we = 1'b0; bus2.dbg_addr = '0; bus2.dbg_wdata = '0;
    #2;
    test_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    test_read();
    test_write();
    test_back_to_back();
    test_mid_reset();
    test_params();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d transactions never acked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences every SRAM access for the SLC-3 and shares the single asynchronous SRAM port between two requesters.
- Requester 0 is the CPU datapath (MAR/MDR path, driven by the ISDU memory states).
- Requester 1 is the debug/program loader.
- Generates active-low SRAM strobes with parameterised wait states, so control-unit memory states reduce to a req/ack handshake.

Parameters:
- RD_WAIT, 2: cycles OE is held low per read; minimum 1.
- WR_WAIT, 2: cycles WE is held low per write; minimum 1.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data; valid when cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same set for requester 1
- sram_addr  out  AW  SRAM address
- sram_dq_out  out  DW  write data to tristate pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_in  in  DW  read data from pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, effective immediately):
  - State = IDLE; sram_ce_n = sram_oe_n = sram_we_n = 1; sram_dq_oe = 0.
  - sram_addr = 0, sram_dq_out = 0; both rdata = 0; both ack = 0; busy = 0.
  - last_grant = DBG, so the CPU wins the first tie.
- Reset during a transaction aborts it: strobes release the same cycle, no ack is issued, and the requester must re-request.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - If any req is high, choose the winner: a single requester wins outright; on a tie, the requester that is not last_grant wins.
  - Latch the winner's id, we, addr and wdata; update last_grant; go to SETUP.
  - If no req is high, stay in IDLE.
- SETUP (1 cycle):
  - ce_n = 0; sram_addr = latched address; OE and WE high.
  - If write: dq_oe = 1 and dq_out = latched wdata.
  - Load the wait counter with RD_WAIT-1 or WR_WAIT-1; go to ACCESS.
- ACCESS:
  - Read: oe_n = 0. Write: we_n = 0 and data remains driven.
  - Counter decrements each cycle.
  - When the counter reaches 0: on a read, capture sram_dq_in into the winner's rdata register; go to HOLD.
- HOLD (1 cycle):
  - oe_n = we_n = 1; ce_n = 0; address and write data held, so hold time is met.
  - Winner's ack = 1 for exactly this cycle; go to IDLE.
  - The loser's ack stays 0.
- Latency from the cycle req is sampled in IDLE to the ack cycle:
  - Read: RD_WAIT + 3 cycles (5 at default).
  - Write: WR_WAIT + 3 cycles.
- Handshake rules:
  - Requester fields are sampled only in IDLE; changes after grant are ignored.
  - If req is still high in the cycle after ack, it is a new transaction.
  - Round-robin applies, so continuous requests from both sides alternate strictly: CPU, DBG, CPU, ...
- Only the winner's rdata updates; the other rdata register holds its value.
- Never allowed: oe_n = 0 and we_n = 0 together; dq_oe = 1 during a read; any strobe low while ce_n = 1.

Decomposition:
- Package slc3_mem_pkg contains:
  - mem_state_t enum (IDLE, SETUP, ACCESS, HOLD).
  - req_id_t enum (CPU, DBG).
  - Default constants SLC3_RD_WAIT = 2 and SLC3_WR_WAIT = 2.
- One sub-module, mem_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_id.

Test Plan:
- Read: CPU read, addr 0x0040, SRAM model returns 0x1234 -> oe_n low for exactly 2 cycles; cpu_ack pulses 5 cycles after req sampled; cpu_rdata = 0x1234; dbg_ack stays 0.
- Write: DBG write, addr 0x00FF, data 0xBEEF -> dq_oe high across SETUP through HOLD; we_n low 2 cycles; SRAM model location 0x00FF = 0xBEEF; dbg_ack pulses once.
- Tie from reset: cpu_req and dbg_req rise together after reset -> CPU is served first, DBG next. Held continuously for 4 transactions -> grant order CPU, DBG, CPU, DBG.
- Mid-access reset: Reset asserted in the second ACCESS cycle of a write -> all strobes high and dq_oe = 0 in the same cycle; no ack; after release, busy = 0 and state is IDLE.
- Parameters and protocol: RD_WAIT = 4, WR_WAIT = 1 build -> read ack at cycle 7, write ack at cycle 4. Assertion checks run throughout: oe_n and we_n never both low; ack is always exactly 1 cycle wide.
